// File: rtl/line_fetch.sv
// Streams a burst of RAM words (base_addr, len) out on a valid/ready port.
// RAM read data bypasses a 2-entry FIFO, so the first word is valid 2 cycles after start.
module line_fetch #(
  parameter int DW = 8,
  parameter int AW = 9
) (
  input  logic          CLKA,
  input  logic          rstb,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic          ram_ce,
  output logic          ram_wr,
  output logic [AW-1:0] ram_addr,
  input  logic [DW-1:0] ram_dout,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  localparam logic [AW:0]   LEN_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

  state_t        state, state_nxt;
  logic [AW:0]   len_q, issued, accepted, issued_inc;
  logic [AW-1:0] addr_q;
  logic          in_flight;
  logic [1:0]    occ;
  logic [DW-1:0] mem [2];
  logic          wr_ptr, rd_ptr;
  logic          done_q;
  logic [2:0]    outstanding;
  logic          issue, pop, pop_fifo, push, last_word;

  assign issued_inc  = issued + LEN_ONE;
  assign outstanding = {1'b0, occ} + {2'b00, in_flight};
  assign last_word   = (accepted == len_q - LEN_ONE);

  // Words come from the FIFO head when it holds any, else straight from the RAM.
  assign m_valid  = (occ != 2'd0) || in_flight;
  assign m_data   = (occ != 2'd0) ? mem[rd_ptr] : (in_flight ? ram_dout : '0);
  assign m_last   = m_valid && last_word;
  assign pop      = m_valid && m_ready;
  assign pop_fifo = pop && (occ != 2'd0);
  assign push     = in_flight && !((occ == 2'd0) && m_ready);

  assign ram_wr   = 1'b0;
  assign ram_addr = addr_q;
  assign done     = done_q;

  always_ff @(posedge CLKA) begin
    if (rstb) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && (len != '0)) state_nxt = FETCH;
      FETCH:   if (issue && (issued_inc == len_q)) state_nxt = DRAIN;
      DRAIN:   if (pop && last_word) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A read is only issued when its word is guaranteed a FIFO slot.
  always_comb begin
    busy   = (state != IDLE);
    issue  = (state == FETCH) && (issued != len_q) && (outstanding < 3'd2);
    ram_ce = issue;
  end

  always_ff @(posedge CLKA) begin
    if (rstb) begin
      len_q     <= '0;
      issued    <= '0;
      accepted  <= '0;
      addr_q    <= '0;
      in_flight <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      in_flight <= issue;
      if ((state == IDLE) && start) begin
        if (len == '0) begin
          done_q <= 1'b1;
        end else begin
          len_q    <= len;
          addr_q   <= base_addr;
          issued   <= '0;
          accepted <= '0;
        end
      end
      if (issue) begin
        addr_q <= addr_q + ADDR_ONE;
        issued <= issued_inc;
      end
      if (pop) accepted <= accepted + LEN_ONE;
      if ((state == DRAIN) && pop && last_word) done_q <= 1'b1;
    end
  end

  always_ff @(posedge CLKA) begin
    if (rstb) begin
      occ    <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= ram_dout;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_fifo) rd_ptr <= ~rd_ptr;
      case ({push, pop_fifo})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_line_fetch.sv
// Directed bench for line_fetch: RAM model returns addr[7:0] one cycle after ram_ce.
module tb_line_fetch;

  logic       CLKA = 1'b0;
  logic       rstb;
  logic       start;
  logic [8:0] base_addr;
  logic [9:0] len;
  logic       busy, done, ram_ce, ram_wr;
  logic [8:0] ram_addr;
  logic [7:0] ram_dout;
  logic       m_valid, m_ready, m_last;
  logic [7:0] m_data;

  int n_cmp = 0;
  int n_bad = 0;

  logic [8:0] got_addr[$];
  logic [7:0] got_data[$];
  logic       got_last[$];
  int done_cnt, done_cyc, first_vld, vld_seen, busy_seen, max_out, ce_bad;

  line_fetch #(.DW(8), .AW(9)) dut (
    .CLKA(CLKA), .rstb(rstb), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .ram_ce(ram_ce), .ram_wr(ram_wr), .ram_addr(ram_addr),
    .ram_dout(ram_dout), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last)
  );

  always #5 CLKA = ~CLKA;

  always @(posedge CLKA) if (ram_ce) ram_dout <= ram_addr[7:0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // rmode 0: ready always high; rmode 1: ready pattern 1,0,0,1 repeating.
  // A second start (base 0x0AA, len 3) is pulsed at cycle extra_cyc when > 0.
  task automatic run_burst(input logic [8:0] b, input logic [9:0] n, input int rmode,
                           input int budget, input int extra_cyc);
    int issued_cnt, acc_cnt, out;
    got_addr.delete(); got_data.delete(); got_last.delete();
    done_cnt = 0; done_cyc = -1; first_vld = -1; vld_seen = 0; busy_seen = 0;
    max_out = 0; ce_bad = 0; issued_cnt = 0; acc_cnt = 0;
    @(negedge CLKA);
    start = 1'b1; base_addr = b; len = n; m_ready = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge CLKA);
      start     = (c == extra_cyc);
      base_addr = (c == extra_cyc) ? 9'h0AA : b;
      len       = (c == extra_cyc) ? 10'd3 : n;
      m_ready   = (rmode == 0) || (c % 4 == 0) || (c % 4 == 3);
      out = issued_cnt - acc_cnt;
      if (out > max_out) max_out = out;
      if (ram_ce) begin
        if (out >= 2) ce_bad++;
        got_addr.push_back(ram_addr);
        issued_cnt++;
      end
      if (busy) busy_seen++;
      if (m_valid) begin
        vld_seen++;
        if (first_vld < 0) first_vld = c;
      end
      if (m_valid && m_ready) begin
        got_data.push_back(m_data);
        got_last.push_back(m_last);
        acc_cnt++;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0 && c >= done_cyc + 3) break;
    end
    start = 1'b0;
  endtask

  task automatic chk_stream(input string tag, input logic [8:0] b, input int n);
    int dbad, lbad, abad;
    dbad = 0; lbad = 0; abad = 0;
    chk({tag, "_ncount"}, got_data.size(), n);
    chk({tag, "_ce_count"}, got_addr.size(), n);
    for (int i = 0; i < got_data.size() && i < n; i++) begin
      logic [8:0] a;
      a = b + 9'(i);
      if (got_data[i] !== a[7:0]) dbad++;
      if (got_last[i] !== (i == n - 1)) lbad++;
    end
    for (int i = 0; i < got_addr.size() && i < n; i++) begin
      logic [8:0] a;
      a = b + 9'(i);
      if (got_addr[i] !== a) abad++;
    end
    chk({tag, "_data_errs"}, dbad, 0);
    chk({tag, "_last_errs"}, lbad, 0);
    chk({tag, "_addr_errs"}, abad, 0);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_max_out_le2"}, (max_out <= 2), 1);
    chk({tag, "_ce_when_full"}, ce_bad, 0);
  endtask

  initial begin
    int bits_seen;
    bit seen[512];
    rstb = 1'b1; start = 1'b0; base_addr = '0; len = '0; m_ready = 1'b1;
    repeat (2) @(negedge CLKA);
    start = 1'b1; len = 10'd4;
    @(negedge CLKA);
    start = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ce", ram_ce, 0);
    chk("rst_wr", ram_wr, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_data", m_data, 0);
    chk("rst_addr", ram_addr, 0);
    rstb = 1'b0;
    @(negedge CLKA);
    chk("rst_start_ignored_busy", busy, 0);
    chk("rst_start_ignored_ce", ram_ce, 0);

    // Basic burst with latency check
    run_burst(9'h010, 10'd4, 0, 40, 0);
    chk_stream("b4", 9'h010, 4);
    chk("b4_first_valid_cyc", first_vld, 2);
    chk("b4_done_cyc", done_cyc, 6);
    chk("b4_busy_cycles", busy_seen, 5);

    run_burst(9'h1FE, 10'd4, 0, 40, 0);
    chk_stream("wrap4", 9'h1FE, 4);
    chk("wrap4_addr2", got_addr.size() > 2 ? got_addr[2] : 9'h1AA, 9'h000);

    run_burst(9'h040, 10'd8, 1, 80, 0);
    chk_stream("stall8", 9'h040, 8);

    run_burst(9'h033, 10'd0, 0, 20, 0);
    chk("len0_done_cnt", done_cnt, 1);
    chk("len0_done_cyc", done_cyc, 1);
    chk("len0_ce", got_addr.size(), 0);
    chk("len0_valid", vld_seen, 0);
    chk("len0_busy", busy_seen, 0);

    run_burst(9'h020, 10'd6, 1, 80, 3);
    chk_stream("restart6", 9'h020, 6);

    // Mid-burst abort
    @(negedge CLKA);
    start = 1'b1; base_addr = 9'h080; len = 10'd8; m_ready = 1'b1;
    @(negedge CLKA);
    start = 1'b0;
    @(negedge CLKA);
    chk("abort_w0", m_data, 8'h80);
    @(negedge CLKA);
    chk("abort_w1", m_data, 8'h81);
    @(negedge CLKA);
    chk("abort_w2", m_data, 8'h82);
    rstb = 1'b1;
    @(negedge CLKA);
    rstb = 1'b0;
    chk("abort_valid", m_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_ce", ram_ce, 0);
    chk("abort_data", m_data, 0);
    chk("abort_addr", ram_addr, 0);
    begin
      int stray;
      stray = 0;
      repeat (3) begin
        @(negedge CLKA);
        if (done || m_valid || busy || ram_ce) stray++;
      end
      chk("abort_quiet", stray, 0);
    end
    run_burst(9'h0C0, 10'd2, 0, 30, 0);
    chk_stream("post_abort2", 9'h0C0, 2);

    // Full address space, wrapping through 0
    run_burst(9'h005, 10'd512, 0, 600, 0);
    chk_stream("full512", 9'h005, 512);
    chk("full512_done_cyc", done_cyc, 514);
    for (int i = 0; i < 512; i++) seen[i] = 1'b0;
    foreach (got_addr[i]) seen[got_addr[i]] = 1'b1;
    bits_seen = 0;
    for (int i = 0; i < 512; i++) if (seen[i]) bits_seen++;
    chk("full512_distinct_addr", bits_seen, 512);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
